// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds the op encodings, the FSM state type and small op-decoding helpers.
// No logic of its own; imported by muldiv_unit.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  // The encoding puts divide in bit 1 and "unsigned" in bit 0.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
// Ports: acc/q = high/low halves of the partial value, operand = multiplicand
// or divisor, div_mode selects divide; outputs next halves and the quotient bit.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] operand,
  input  logic             div_mode,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] q_next,
  output logic             q_bit
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum      = {1'b0, acc} + {1'b0, operand};
    shifted  = {acc, q[WIDTH-1]};
    diff     = shifted - {1'b0, operand};
    acc_next = acc;
    q_next   = q;
    q_bit    = 1'b0;
    if (div_mode) begin
      // The remainder stays below the divisor, so bit WIDTH of diff is a
      // clean borrow flag: set means the trial subtract must be undone.
      q_bit    = ~diff[WIDTH];
      acc_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      // Quotient bit is returned separately; the caller ORs it into bit 0.
      q_next   = {q[WIDTH-2:0], 1'b0};
    end else if (q[0]) begin
      {acc_next, q_next} = {sum, q[WIDTH-1:1]};
    end else begin
      {acc_next, q_next} = {1'b0, acc, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Ports: start/op/a/b launch an op; hi_we/lo_we/wdata are MTHI/MTLO;
// busy, done, div_by_zero report progress; hi/lo are the result registers.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t           state;
  logic             div_r;
  logic             sign_a;
  logic             sign_b;
  logic             b_zero;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [CNT_W-1:0] cnt;

  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] q_next;
  logic             q_bit;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  // The iteration runs on magnitudes; signs are reapplied in FIX.
  // Signed MIN has no positive twin, but its negation is the same bit
  // pattern, which read as unsigned is exactly the magnitude needed.
  always_comb begin
    neg_a = op_is_signed(op) & a[WIDTH-1];
    neg_b = op_is_signed(op) & b[WIDTH-1];
    mag_a = neg_a ? -a : a;
    mag_b = neg_b ? -b : b;
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .q        (q),
    .operand  (operand),
    .div_mode (div_r),
    .acc_next (acc_next),
    .q_next   (q_next),
    .q_bit    (q_bit)
  );

  // Sign correction and the divide-by-zero override.
  // MIN / -1 needs no special case: the magnitude quotient 2^(WIDTH-1) is MIN.
  always_comb begin
    res_hi = acc;
    res_lo = q;
    if (!div_r) begin
      {res_hi, res_lo} = (sign_a ^ sign_b) ? -{acc, q} : {acc, q};
    end else if (b_zero) begin
      res_hi = a_raw;
      res_lo = '1;
    end else begin
      res_lo = (sign_a ^ sign_b) ? -q : q;
      res_hi = sign_a ? -acc : acc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_r       <= 1'b0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      b_zero      <= 1'b0;
      a_raw       <= '0;
      operand     <= '0;
      acc         <= '0;
      q           <= '0;
      cnt         <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            div_r   <= op_is_div(op);
            sign_a  <= neg_a;
            sign_b  <= neg_b;
            b_zero  <= (b == '0);
            a_raw   <= a;
            // Multiply: operand = multiplicand, q = multiplier.
            // Divide:   operand = divisor,      q = dividend.
            operand <= op_is_div(op) ? mag_b : mag_a;
            q       <= op_is_div(op) ? mag_a : mag_b;
            acc     <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          acc <= acc_next;
          q   <= q_next | {{(WIDTH-1){1'b0}}, q_bit};
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) state <= S_FIX;
        end
        S_FIX: begin
          hi          <= res_hi;
          lo          <= res_lo;
          done        <= 1'b1;
          div_by_zero <= div_r & b_zero;
          busy        <= 1'b0;
          state       <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit at WIDTH=32 and WIDTH=8.
// Directed corner cases plus randomized ops against an arithmetic model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start32 = 1'b0;
  logic        start8 = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;

  logic        busy32, done32, dbz32;
  logic [31:0] hi32, lo32;
  logic        busy8, done8, dbz8;
  logic [7:0]  hi8, lo8;

  int cur_w = 32;
  int chk_cnt = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy32), .done(done32), .div_by_zero(dbz32), .hi(hi32), .lo(lo32)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op), .a(a[7:0]), .b(b[7:0]),
    .hi_we(1'b0), .lo_we(1'b0), .wdata(wdata[7:0]),
    .busy(busy8), .done(done8), .div_by_zero(dbz8), .hi(hi8), .lo(lo8)
  );

  logic        s_busy, s_done, s_dbz;
  logic [31:0] s_hi, s_lo;
  assign s_busy = (cur_w == 8) ? busy8 : busy32;
  assign s_done = (cur_w == 8) ? done8 : done32;
  assign s_dbz  = (cur_w == 8) ? dbz8  : dbz32;
  assign s_hi   = (cur_w == 8) ? {24'd0, hi8} : hi32;
  assign s_lo   = (cur_w == 8) ? {24'd0, lo8} : lo32;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: signed/unsigned values as plain integers, native / and %.
  function automatic void ref_model(input int w, input logic [1:0] o,
                                    input logic [31:0] aa, input logic [31:0] bb,
                                    output logic [31:0] rh, output logic [31:0] rl,
                                    output logic rz);
    logic [63:0] mask;
    logic [63:0] ua, ub, p;
    longint      sa, sb, sq, sr;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, aa} & mask;
    ub = {32'd0, bb} & mask;
    sa = aa[w-1] ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
    sb = bb[w-1] ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
    rz = 1'b0;
    rh = '0;
    rl = '0;
    if (o == 2'd0 || o == 2'd1) begin
      p  = (o == 2'd0) ? 64'(sa * sb) : ua * ub;
      rh = 32'((p >> w) & mask);
      rl = 32'(p & mask);
    end else if (ub == 64'd0) begin
      rz = 1'b1;
      rh = 32'(ua);
      rl = 32'(mask);
    end else if (o == 2'd2) begin
      sq = sa / sb;
      sr = sa % sb;
      rl = 32'(64'(sq) & mask);
      rh = 32'(64'(sr) & mask);
    end else begin
      rl = 32'(ua / ub);
      rh = 32'(ua % ub);
    end
  endfunction

  // Present an op and pulse start for one edge; returns at cycle 1 after it.
  task automatic launch(input int w, input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb);
    @(negedge clk);
    cur_w = w;
    op = o; a = aa; b = bb;
    if (w == 8) start8 = 1'b1; else start32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0; start32 = 1'b0;
  endtask

  // Count cycles from `first` until done (bounded), and busy cycles seen.
  task automatic wait_done(input int w, input int first, output int lat, output int bc);
    lat = first;
    bc = 0;
    while (!s_done && lat < w + 10) begin
      if (s_busy) bc++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input int w, input logic [1:0] o,
                        input logic [31:0] aa, input logic [31:0] bb,
                        input logic [31:0] eh, input logic [31:0] el, input logic ez);
    int lat, bc;
    launch(w, o, aa, bb);
    wait_done(w, 1, lat, bc);
    chk({tag, ".lat"}, 64'(lat), 64'(w + 2));
    chk({tag, ".busy"}, 64'(bc), 64'(w + 1));
    chk({tag, ".hi"}, {32'd0, s_hi}, {32'd0, eh});
    chk({tag, ".lo"}, {32'd0, s_lo}, {32'd0, el});
    chk({tag, ".dbz"}, {63'd0, s_dbz}, {63'd0, ez});
    @(negedge clk);
    chk({tag, ".done_clr"}, {62'd0, s_done, s_dbz}, 64'd0);
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done32) cnt++;
    end
  endtask

  initial begin
    int lat, bc, nd, w, sel;
    logic [1:0]  o;
    logic [31:0] aa, bb, eh, el;
    logic        ez;

    #1;
    chk("rst.state", {30'd0, busy32, done32, dbz32, busy8}, 64'd0);
    chk("rst.hilo", {hi32, lo32}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed, WIDTH=32
    run_op("multu_max", 32, 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op("mult_neg", 32, 2'd0, 32'hFFFFFFF9, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run_op("divu", 32, 2'd3, 32'd100, 32'd13, 32'd9, 32'd7, 1'b0);
    run_op("div_neg", 32, 2'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("div_zero", 32, 2'd2, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1);
    run_op("divu_zero", 32, 2'd3, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1);
    run_op("div_min", 32, 2'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0);

    // Directed, WIDTH=8
    run_op("w8_multu", 8, 2'd1, 32'hFF, 32'hFF, 32'hFE, 32'h01, 1'b0);
    run_op("w8_mult", 8, 2'd0, 32'hF9, 32'd3, 32'hFF, 32'hEB, 1'b0);
    run_op("w8_divu", 8, 2'd3, 32'd100, 32'd13, 32'd9, 32'd7, 1'b0);
    run_op("w8_div", 8, 2'd2, 32'hF9, 32'd2, 32'hFF, 32'hFD, 1'b0);

    // start while busy is ignored
    launch(32, 2'd3, 32'd100, 32'd13);
    repeat (4) @(negedge clk);
    op = 2'd1; a = 32'd7; b = 32'd7; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    wait_done(32, 6, lat, bc);
    chk("ign.lat", 64'(lat), 64'd34);
    chk("ign.lo", {32'd0, lo32}, 64'd7);
    chk("ign.hi", {32'd0, hi32}, 64'd9);
    count_dones(40, nd);
    chk("ign.no_second", 64'(nd), 64'd0);

    // MTHI in idle, then MTHI while busy is ignored, MTLO in DONE overrides
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h12345678;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi.idle", {32'd0, hi32}, 64'h12345678);
    launch(32, 2'd1, 32'd2, 32'd3);
    repeat (2) @(negedge clk);
    hi_we = 1'b1; wdata = 32'hDEAD;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi.busy", {32'd0, hi32}, 64'h12345678);
    wait_done(32, 4, lat, bc);
    chk("mthi.res_hi", {32'd0, hi32}, 64'd0);
    chk("mthi.res_lo", {32'd0, lo32}, 64'd6);
    lo_we = 1'b1; wdata = 32'hABCD;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo.done", {32'd0, lo32}, 64'hABCD);

    // Back-to-back: start in the DONE cycle
    launch(32, 2'd1, 32'd3, 32'd4);
    wait_done(32, 1, lat, bc);
    chk("b2b.first_lo", {32'd0, lo32}, 64'd12);
    op = 2'd3; a = 32'd9; b = 32'd2; start32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start32 = 1'b0;
    wait_done(32, 1, lat, bc);
    chk("b2b.lat", 64'(lat), 64'd34);
    chk("b2b.lo", {32'd0, lo32}, 64'd4);
    chk("b2b.hi", {32'd0, hi32}, 64'd1);

    // Reset in the middle of a MULT
    launch(32, 2'd0, 32'hFFFFFFF9, 32'd3);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst.busy_done", {62'd0, busy32, done32}, 64'd0);
    chk("midrst.hilo", {hi32, lo32}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    count_dones(40, nd);
    chk("midrst.no_done", 64'(nd), 64'd0);

    // Randomized ops against the model
    for (int i = 0; i < 48; i++) begin
      w   = (i % 3 == 0) ? 8 : 32;
      o   = 2'($urandom_range(0, 3));
      aa  = $urandom;
      bb  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) bb = 32'd0;
      else if (sel == 1) bb = $urandom_range(1, 20);
      else if (sel == 2) begin
        aa = 32'd1 << (w - 1);
        bb = 32'hFFFFFFFF;
      end
      ref_model(w, o, aa, bb, eh, el, ez);
      run_op($sformatf("rnd%0d", i), w, o, aa, bb, eh, el, ez);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
